// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : ID-stage decoder with registered ID/EX control bundle, load-use
//             hazard detection, multi-cycle divide hold, stall and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int ENABLE_M   = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic        ex_regwrt,
  output logic        ex_memwrt,
  output logic        ex_jmp,
  output logic        ex_brnch,
  output logic        ex_aluSrc,
  output logic [1:0]  ex_rsltSrc,
  output logic [1:0]  ex_ujMux,
  output logic [2:0]  ex_immSrc,
  output logic [3:0]  ex_aluCtrl,
  output logic        ex_mdu,
  output logic [2:0]  ex_funct3,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        ex_illegal,
  output logic        ex_busy
);

  localparam int              CW         = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0]   C_DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0]   C_ONE      = CW'(1);

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  localparam logic [3:0] C_ALU_ADD  = 4'b0000;
  localparam logic [3:0] C_ALU_SUB  = 4'b0001;
  localparam logic [3:0] C_ALU_AND  = 4'b0010;
  localparam logic [3:0] C_ALU_OR   = 4'b0011;
  localparam logic [3:0] C_ALU_XOR  = 4'b0100;
  localparam logic [3:0] C_ALU_SLL  = 4'b0101;
  localparam logic [3:0] C_ALU_SRL  = 4'b0110;
  localparam logic [3:0] C_ALU_SLT  = 4'b0111;
  localparam logic [3:0] C_ALU_SRA  = 4'b1000;
  localparam logic [3:0] C_ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic       valid;
    logic       regwrt;
    logic       memwrt;
    logic       jmp;
    logic       brnch;
    logic       aluSrc;
    logic [1:0] rsltSrc;
    logic [1:0] ujMux;
    logic [2:0] immSrc;
    logic [3:0] aluCtrl;
    logic       mdu;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ex_bundle_t;

  logic [6:0]    w_opcode;
  logic [2:0]    w_funct3;
  logic [6:0]    w_funct7;
  logic [3:0]    w_alu_f3;
  logic          w_rs1_used;
  logic          w_rs2_used;
  logic          w_load_use;
  logic          w_busy;
  ex_bundle_t    w_dec;
  ex_bundle_t    ex_q, ex_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  // ALU operation implied by funct3 for OP-IMM and R-type; bit 30 picks SRA
  always_comb begin
    w_alu_f3 = C_ALU_ADD;
    case (w_funct3)
      3'b000: w_alu_f3 = C_ALU_ADD;
      3'b001: w_alu_f3 = C_ALU_SLL;
      3'b010: w_alu_f3 = C_ALU_SLT;
      3'b011: w_alu_f3 = C_ALU_SLTU;
      3'b100: w_alu_f3 = C_ALU_XOR;
      3'b101: w_alu_f3 = instr[30] ? C_ALU_SRA : C_ALU_SRL;
      3'b110: w_alu_f3 = C_ALU_OR;
      default: w_alu_f3 = C_ALU_AND;
    endcase
  end

  // Main decoder: unknown opcodes and disabled M ops become illegal with no controls
  always_comb begin
    w_dec        = '0;
    w_dec.valid  = 1'b1;
    w_dec.funct3 = w_funct3;
    w_dec.rd     = instr[11:7];
    w_dec.rs1    = instr[19:15];
    w_dec.rs2    = instr[24:20];
    case (w_opcode)
      C_OP_LOAD: begin
        w_dec.regwrt  = 1'b1;
        w_dec.aluSrc  = 1'b1;
        w_dec.rsltSrc = 2'b01;
      end
      C_OP_OPIMM: begin
        w_dec.regwrt  = 1'b1;
        w_dec.aluSrc  = 1'b1;
        w_dec.aluCtrl = w_alu_f3;
      end
      C_OP_OP: begin
        if (w_funct7 == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            w_dec.mdu    = 1'b1;
            w_dec.regwrt = 1'b1;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end else begin
          w_dec.regwrt  = 1'b1;
          w_dec.aluCtrl = ((w_funct3 == 3'b000) && instr[30]) ? C_ALU_SUB : w_alu_f3;
        end
      end
      C_OP_STORE: begin
        w_dec.memwrt = 1'b1;
        w_dec.immSrc = 3'b001;
        w_dec.aluSrc = 1'b1;
      end
      C_OP_BRANCH: begin
        w_dec.brnch  = 1'b1;
        w_dec.immSrc = 3'b010;
        case (w_funct3[2:1])
          2'b00:   w_dec.aluCtrl = C_ALU_SUB;
          2'b10:   w_dec.aluCtrl = C_ALU_SLT;
          2'b11:   w_dec.aluCtrl = C_ALU_SLTU;
          default: w_dec.aluCtrl = C_ALU_ADD;
        endcase
      end
      C_OP_LUI: begin
        w_dec.regwrt  = 1'b1;
        w_dec.immSrc  = 3'b100;
        w_dec.rsltSrc = 2'b11;
      end
      C_OP_AUIPC: begin
        w_dec.regwrt  = 1'b1;
        w_dec.immSrc  = 3'b100;
        w_dec.rsltSrc = 2'b11;
        w_dec.ujMux   = 2'b01;
      end
      C_OP_JAL: begin
        w_dec.regwrt  = 1'b1;
        w_dec.jmp     = 1'b1;
        w_dec.immSrc  = 3'b011;
        w_dec.rsltSrc = 2'b10;
        w_dec.ujMux   = 2'b01;
      end
      C_OP_JALR: begin
        w_dec.regwrt  = 1'b1;
        w_dec.jmp     = 1'b1;
        w_dec.rsltSrc = 2'b10;
        w_dec.ujMux   = 2'b10;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // A load is the only instruction that registers rsltSrc=01, so it identifies a load in EX
  assign w_rs1_used = (w_opcode != C_OP_LUI) && (w_opcode != C_OP_AUIPC) && (w_opcode != C_OP_JAL);
  assign w_rs2_used = (w_opcode == C_OP_OP) || (w_opcode == C_OP_STORE) || (w_opcode == C_OP_BRANCH);
  assign w_load_use = instr_valid && ex_q.valid && (ex_q.rsltSrc == 2'b01) && (ex_q.rd != 5'd0) &&
                      ((w_rs1_used && (instr[19:15] == ex_q.rd)) ||
                       (w_rs2_used && (instr[24:20] == ex_q.rd)));
  assign w_busy     = ex_q.valid && ex_q.mdu && ex_q.funct3[2] && (cnt_q != '0);
  assign id_ready   = !stall_in && !w_busy && !w_load_use;

  // Next EX contents: stall holds all, divide hold counts down, else bubble or new bundle
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!stall_in) begin
      if (w_busy) begin
        cnt_d = cnt_q - C_ONE;
      end else if (flush || w_load_use || !instr_valid) begin
        ex_d  = '0;
        cnt_d = '0;
      end else begin
        ex_d  = w_dec;
        cnt_d = (w_dec.mdu && w_dec.funct3[2]) ? C_DIV_LOAD : '0;
      end
    end
  end

  // ID/EX register and divide counter, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_regwrt  = ex_q.regwrt;
  assign ex_memwrt  = ex_q.memwrt;
  assign ex_jmp     = ex_q.jmp;
  assign ex_brnch   = ex_q.brnch;
  assign ex_aluSrc  = ex_q.aluSrc;
  assign ex_rsltSrc = ex_q.rsltSrc;
  assign ex_ujMux   = ex_q.ujMux;
  assign ex_immSrc  = ex_q.immSrc;
  assign ex_aluCtrl = ex_q.aluCtrl;
  assign ex_mdu     = ex_q.mdu;
  assign ex_funct3  = ex_q.funct3;
  assign ex_rd      = ex_q.rd;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_illegal = ex_q.illegal;
  assign ex_busy    = w_busy;

endmodule
`default_nettype wire
